// File: rtl/uart_tx_serializer.sv
// Asynchronous serial transmit engine: start bit, LSB-first data, optional parity, stop bit(s).
// All outputs are registered; busy/done give upstream a back-pressure and completion signal.
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [2:0]       bit_idx, bit_nx;
   logic [7:0]       shift, shift_nx;
   logic             par, par_nx;
   logic             tx_nx, busy_nx, done_nx;
   logic             last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         par     <= 1'b0;
         tx      <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         bit_idx <= bit_nx;
         shift   <= shift_nx;
         par     <= par_nx;
         tx      <= tx_nx;
         busy    <= busy_nx;
         done    <= done_nx;
      end
   end

   assign last = (cnt == CNT_LAST);

   // Outputs are computed for the bit that will be on the line next cycle,
   // so tx/busy/done come straight from flops.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      bit_nx   = bit_idx;
      shift_nx = shift;
      par_nx   = par;
      tx_nx    = tx;
      busy_nx  = busy;
      done_nx  = 1'b0;
      if (state != S_IDLE) begin
         cnt_nx = last ? '0 : cnt + CNT_W'(1);
      end
      case (state)
         S_IDLE: begin
            tx_nx   = 1'b1;
            busy_nx = 1'b0;
            if (start) begin
               shift_nx = data;
               par_nx   = (^data[DATA_BITS-1:0]) ^ (PARITY_ODD != 0);
               cnt_nx   = '0;
               bit_nx   = '0;
               state_nx = S_START;
               tx_nx    = 1'b0;
               busy_nx  = 1'b1;
            end
         end
         S_START: begin
            if (last) begin
               state_nx = S_DATA;
               bit_nx   = '0;
               tx_nx    = shift[0];
            end
         end
         S_DATA: begin
            if (last) begin
               if (bit_idx == DATA_LAST) begin
                  bit_nx = '0;
                  if (PARITY_EN != 0) begin
                     state_nx = S_PARITY;
                     tx_nx    = par;
                  end else begin
                     state_nx = S_STOP;
                     tx_nx    = 1'b1;
                  end
               end else begin
                  bit_nx   = bit_idx + 3'd1;
                  shift_nx = {1'b0, shift[7:1]};
                  tx_nx    = shift[1];
               end
            end
         end
         S_PARITY: begin
            if (last) begin
               state_nx = S_STOP;
               bit_nx   = '0;
               tx_nx    = 1'b1;
            end
         end
         S_STOP: begin
            tx_nx = 1'b1;
            if (last) begin
               if (bit_idx == STOP_LAST) begin
                  state_nx = S_IDLE;
                  busy_nx  = 1'b0;
                  done_nx  = 1'b1;
               end else begin
                  bit_nx = bit_idx + 3'd1;
               end
            end
         end
         default: begin
            state_nx = S_IDLE;
            tx_nx    = 1'b1;
            busy_nx  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four framing variants (8N1, 8E1, 8O1, 8N2) at 4 clocks per bit,
// each frame compared cycle by cycle against a bit list built from the framing rules.
module tb_uart_tx_serializer;
   localparam int CPB  = 4;
   localparam int NDUT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data;
   logic       start_v [NDUT];
   logic       tx_v    [NDUT];
   logic       busy_v  [NDUT];
   logic       done_v  [NDUT];

   int par_en_c  [NDUT] = '{0, 1, 1, 0};
   int par_odd_c [NDUT] = '{0, 0, 1, 0};
   int stop_c    [NDUT] = '{1, 1, 1, 2};

   int   n_cmp  = 0;
   int   n_fail = 0;
   logic exp_q[$];

   // clock / reset
   always #5 clk = ~clk;

   uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
      u_8n1 (.clk(clk), .rst(rst), .start(start_v[0]), .data(data), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
   uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
      u_8e1 (.clk(clk), .rst(rst), .start(start_v[1]), .data(data), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
   uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
      u_8o1 (.clk(clk), .rst(rst), .start(start_v[2]), .data(data), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
   uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
      u_8n2 (.clk(clk), .rst(rst), .start(start_v[3]), .data(data), .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input int d, input string tag);
      check($sformatf("%s d%0d tx", tag, d), {7'd0, tx_v[d]}, 8'd1);
      check($sformatf("%s d%0d busy", tag, d), {7'd0, busy_v[d]}, 8'd0);
      check($sformatf("%s d%0d done", tag, d), {7'd0, done_v[d]}, 8'd0);
   endtask

   task automatic idle_all(input int n, input string tag);
      for (int c = 0; c < n; c++) begin
         for (int d = 0; d < NDUT; d++) check_idle(d, tag);
         @(negedge clk);
      end
   endtask

   // Reference: list of line bits for one frame
   task automatic build_frame(input int d, input logic [7:0] b);
      int ones;
      exp_q.delete();
      ones = 0;
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(b[i]);
         if (b[i]) ones++;
      end
      if (par_en_c[d] != 0) exp_q.push_back(((ones % 2) == 1) != (par_odd_c[d] != 0));
      for (int s = 0; s < stop_c[d]; s++) exp_q.push_back(1'b1);
   endtask

   // Called at a negedge; returns at the negedge of the done cycle.
   task automatic send_frame(input int d, input logic [7:0] b, input int reject_at);
      int total;
      build_frame(d, b);
      total = exp_q.size() * CPB;
      data = b;
      start_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0;
      for (int k = 0; k < total; k++) begin
         check($sformatf("d%0d b%02h tx c%0d", d, b, k), {7'd0, tx_v[d]}, {7'd0, exp_q[k / CPB]});
         check($sformatf("d%0d b%02h busy c%0d", d, b, k), {7'd0, busy_v[d]}, 8'd1);
         check($sformatf("d%0d b%02h done c%0d", d, b, k), {7'd0, done_v[d]}, 8'd0);
         if (k == reject_at) begin
            start_v[d] = 1'b1;
            data = 8'hFF;
         end else begin
            start_v[d] = 1'b0;
         end
         @(negedge clk);
      end
      start_v[d] = 1'b0;
      check($sformatf("d%0d b%02h end done", d, b), {7'd0, done_v[d]}, 8'd1);
      check($sformatf("d%0d b%02h end busy", d, b), {7'd0, busy_v[d]}, 8'd0);
      check($sformatf("d%0d b%02h end tx", d, b), {7'd0, tx_v[d]}, 8'd1);
   endtask

   initial begin
      logic [7:0] b;
      int d;
      rst  = 1'b1;
      data = 8'h00;
      for (int i = 0; i < NDUT; i++) start_v[i] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) check_idle(i, "reset");
      rst = 1'b0;
      idle_all(20, "post reset");

      // 8N1 0x55
      send_frame(0, 8'h55, -1);
      @(negedge clk);
      idle_all(3, "after 55");

      // start while busy is ignored; no second frame afterwards
      send_frame(0, 8'hA3, 10);
      @(negedge clk);
      idle_all(12, "after reject");

      // parity even / odd
      send_frame(1, 8'h07, -1);
      @(negedge clk);
      send_frame(2, 8'h07, -1);
      @(negedge clk);
      idle_all(2, "after parity");

      // back-to-back in the done cycle, 1 and 2 stop bits
      send_frame(0, 8'h12, -1);
      send_frame(0, 8'h34, -1);
      @(negedge clk);
      send_frame(3, 8'h12, -1);
      send_frame(3, 8'h34, -1);
      @(negedge clk);
      idle_all(2, "after b2b");

      // reset during data bit 3
      b = 8'($urandom_range(0, 255));
      data = b;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (17) @(negedge clk);
      check("midframe bit3 tx", {7'd0, tx_v[0]}, {7'd0, b[3]});
      check("midframe busy", {7'd0, busy_v[0]}, 8'd1);
      #1 rst = 1'b1;
      #1;
      check_idle(0, "async reset");
      @(negedge clk);
      rst = 1'b0;
      idle_all(10, "after midframe reset");
      send_frame(0, 8'h81, -1);
      @(negedge clk);

      // random frames, sometimes chained back-to-back
      for (int it = 0; it < 24; it++) begin
         d = $urandom_range(0, NDUT - 1);
         b = 8'($urandom_range(0, 255));
         send_frame(d, b, -1);
         if ($urandom_range(0, 1) == 1) begin
            send_frame(d, 8'($urandom_range(0, 255)), -1);
         end
         @(negedge clk);
         idle_all($urandom_range(1, 3), "random gap");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
